frame_serializer: RTL

//   Downstream of the interleaver. Latches one interleaved frame of n*symbol_num bits
//   and shifts it out serially, one bit per accepted transfer, to the channel/modulator stage.

---
 rtl/frame_serializer_if.sv | 18 +
 rtl/frame_serializer.sv | 81 ++++++++
 2 files changed

// File: rtl/frame_serializer_if.sv
// Handshake bundle between the interleaver (parallel load side) and the
// serial channel side of the frame serializer.
interface frame_serializer_if #(parameter int FRAME_LEN = 35);
  logic                 en;
  logic [FRAME_LEN-1:0] data_i;
  logic                 ready_o;
  logic                 bit_ready;
  logic                 bit_o;
  logic                 bit_valid;
  logic                 sof;
  logic                 eof;
  logic                 ovf;

  modport master (output en, data_i, bit_ready,
                  input  ready_o, bit_o, bit_valid, sof, eof, ovf);
  modport slave  (input  en, data_i, bit_ready,
                  output ready_o, bit_o, bit_valid, sof, eof, ovf);
endinterface

// File: rtl/frame_serializer.sv
// Latches one interleaved frame and shifts it out LSB first over a valid/ready
// serial link; flags first/last bits and records frames dropped on overflow.
module frame_serializer #(
  parameter int n          = 7,
  parameter int symbol_num = 5
) (
  input  logic clk,
  input  logic rst,
  frame_serializer_if.slave bus
);
  localparam int FRAME_LEN = n * symbol_num;
  localparam int CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state, state_nxt;
  logic [FRAME_LEN-1:0] shift_reg;
  logic [CW-1:0]        count;
  logic                 ovf_r;
  logic                 ready, valid, last, xfer, accept;

  assign last   = (count == LAST);
  assign xfer   = (state == SHIFT) && bus.bit_ready;
  assign accept = bus.en && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ready opens on the eof transfer so the next frame follows with no gap
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.en) state_nxt = SHIFT;
      end
      SHIFT: begin
        valid = 1'b1;
        if (bus.bit_ready && last) begin
          ready = 1'b1;
          if (!bus.en) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      count     <= '0;
      ovf_r     <= 1'b0;
    end else begin
      if (accept) begin
        shift_reg <= bus.data_i;
        count     <= '0;
      end else if (xfer && last) begin
        // clear on frame end so an idle line shows no stale data
        shift_reg <= '0;
        count     <= '0;
      end else if (xfer) begin
        shift_reg <= shift_reg >> 1;
        count     <= count + 1'b1;
      end
      if (bus.en && !ready) ovf_r <= 1'b1;
    end
  end

  // held low during reset so every output reads 0 while rst is asserted
  assign bus.ready_o   = ready && !rst;
  assign bus.bit_valid = valid;
  assign bus.bit_o     = shift_reg[0];
  assign bus.sof       = valid && (count == '0);
  assign bus.eof       = valid && last;
  assign bus.ovf       = ovf_r;
endmodule
